regfile_wb_arbiter: RTL and testbench

Write-back arbiter that owns the register file's single write port (WE3/A3/WD3) in the RISC-V core. It merges same-cycle ALU/immediate results with delayed load-data returns from the data-memory side, buffers load returns in a small FIFO, and drops writes to x0. It also reports pending-load hazards for two source addresses.

---
 rtl/regfile_wb_arbiter_if.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bundle: ALU result, load return handshake, hazard query, register-file write port.
// Latency: none (signal container only).
// Backpressure: ld_valid/ld_ready on the load side; stall is the only throttle on the ALU side.
//
// Signals:
//   alu_valid/alu_rd/alu_data  ALU result (core -> arbiter), never back-pressured
//   ld_valid/ld_ready/ld_rd/ld_data  load-data return handshake
//   q1/q2 -> haz1/haz2          pending-load hazard query for two source addresses
//   stall, ld_count             starvation throttle and FIFO occupancy
//   WE3/A3/WD3                  registered register-file write port
interface regfile_wb_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [4:0]    ld_rd;
    logic [31:0]   ld_data;
    logic [4:0]    q1;
    logic [4:0]    q2;
    logic          haz1;
    logic          haz2;
    logic          stall;
    logic [CW-1:0] ld_count;
    logic          WE3;
    logic [4:0]    A3;
    logic [31:0]   WD3;

    // Core / testbench side.
    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, q1, q2,
        input  ld_ready, haz1, haz2, stall, ld_count, WE3, A3, WD3
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, q1, q2,
        output ld_ready, haz1, haz2, stall, ld_count, WE3, A3, WD3
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Owns the register file's single write port: ALU results win, queued load returns fill idle slots, x0 writes dropped.
// Latency: ALU result 1 cycle to WE3; load 2 cycles through the FIFO (1 cycle when WB_LOAD_BYPASS_EN bypasses an idle FIFO).
// Backpressure: ld_ready low while the FIFO is full (registered occupancy only); stall asks the core to idle the ALU
//               once the FIFO head has been blocked STARVE_LIMIT consecutive cycles.
//
// Ports: clk, rst (async, active-low), wb (regfile_wb_arbiter_if.slave) carrying the ALU result, the load-return
//        handshake, hazard queries q1/q2 -> haz1/haz2, stall, ld_count and the registered WE3/A3/WD3 write port.
// Optional feature: define WB_LOAD_BYPASS_EN to send a load straight to the write port when the FIFO is empty and
//                   the ALU is not writing that cycle.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;
    logic          stall_q;
    logic          we_q;
    logic [4:0]    a3_q;
    logic [31:0]   wd3_q;

    logic          ld_ready_int;
    logic          alu_win;
    logic          fifo_nonempty;
    logic          pop;
    logic          accept;
    logic          push;
    logic          bypass;
    logic [SW-1:0] starve_nxt;
    logic          haz1_c;
    logic          haz2_c;
    logic [PW-1:0] offs;

    // Readiness depends only on registered occupancy, so a same-cycle pop never frees a slot early.
    assign ld_ready_int = rst && (count != FULL);

    always_comb begin
        alu_win       = wb.alu_valid && (wb.alu_rd != 5'd0);
        fifo_nonempty = (count != '0);
        pop           = !alu_win && fifo_nonempty;
        accept        = wb.ld_valid && ld_ready_int;
        bypass        = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
        bypass        = accept && (wb.ld_rd != 5'd0) && !fifo_nonempty && !alu_win;
`endif
        // Loads to x0 are accepted and dropped here.
        push          = accept && (wb.ld_rd != 5'd0) && !bypass;

        starve_nxt = starve;
        if (pop) begin
            starve_nxt = '0;
        end else if (alu_win && fifo_nonempty && (starve != SLIM)) begin
            starve_nxt = starve + 1'b1;
        end
    end

    // Hazard scan: entry i is live when its distance from the head is below the occupancy.
    always_comb begin
        haz1_c = 1'b0;
        haz2_c = 1'b0;
        offs   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rd_ptr;
            if ({1'b0, offs} < count) begin
                if ((wb.q1 != 5'd0) && (mem[i].rd == wb.q1)) haz1_c = 1'b1;
                if ((wb.q2 != 5'd0) && (mem[i].rd == wb.q2)) haz2_c = 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{rd: wb.ld_rd, data: wb.ld_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            starve  <= '0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            a3_q    <= 5'd0;
            wd3_q   <= 32'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            starve  <= starve_nxt;
            // Looks at the next counter value so stall drops right after the edge that pops the head.
            stall_q <= (starve_nxt == SLIM);

            we_q <= alu_win || pop || bypass;
            if (alu_win) begin
                a3_q  <= wb.alu_rd;
                wd3_q <= wb.alu_data;
            end else if (pop) begin
                a3_q  <= mem[rd_ptr].rd;
                wd3_q <= mem[rd_ptr].data;
            end else if (bypass) begin
                a3_q  <= wb.ld_rd;
                wd3_q <= wb.ld_data;
            end
        end
    end

    assign wb.ld_ready = ld_ready_int;
    assign wb.haz1     = haz1_c;
    assign wb.haz2     = haz2_c;
    assign wb.stall    = stall_q;
    assign wb.ld_count = count;
    assign wb.WE3      = we_q;
    assign wb.A3       = a3_q;
    assign wb.WD3      = wd3_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by random traffic, checked against a queue model.
// Latency: n/a.
// Backpressure: the bench honours ld_ready and keeps alu_valid low while the model predicts stall.
module tb_regfile_wb_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DEPTH(DEPTH)) wb_if ();

    regfile_wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb_if)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending loads in order, plus the expected registered outputs.
    ent_t        mq[$];
    int          starve = 0;
    logic        m_we = 1'b0;
    logic [4:0]  m_a3 = 5'd0;
    logic [31:0] m_wd = 32'd0;
    logic        m_stall = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic hz(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ldd,
                         input logic [4:0] a1, input logic [4:0] a2);
        wb_if.alu_valid = av;
        wb_if.alu_rd    = ar;
        wb_if.alu_data  = ad;
        wb_if.ld_valid  = lv;
        wb_if.ld_rd     = lr;
        wb_if.ld_data   = ldd;
        wb_if.q1        = a1;
        wb_if.q2        = a2;
    endtask

    // One clock: compare DUT against the model mid-cycle, advance the model from the applied inputs,
    // then return #1 after the rising edge.
    task automatic step();
        logic alu_w, acc, byp;
        ent_t e;
        @(negedge clk);
        chk("ld_ready", {31'd0, wb_if.ld_ready}, {31'd0, mq.size() != DEPTH});
        chk("haz1", {31'd0, wb_if.haz1}, {31'd0, hz(wb_if.q1)});
        chk("haz2", {31'd0, wb_if.haz2}, {31'd0, hz(wb_if.q2)});
        chk("WE3", {31'd0, wb_if.WE3}, {31'd0, m_we});
        if (m_we) begin
            chk("A3", {27'd0, wb_if.A3}, {27'd0, m_a3});
            chk("WD3", wb_if.WD3, m_wd);
        end
        chk("stall", {31'd0, wb_if.stall}, {31'd0, m_stall});
        chk("ld_count", 32'(wb_if.ld_count), 32'(mq.size()));

        alu_w = wb_if.alu_valid && (wb_if.alu_rd != 5'd0);
        acc   = wb_if.ld_valid && (mq.size() != DEPTH);
        byp   = 1'b0;
        if (alu_w) begin
            m_we = 1'b1; m_a3 = wb_if.alu_rd; m_wd = wb_if.alu_data;
            if (mq.size() != 0 && starve < STARVE_LIMIT) starve++;
        end else if (mq.size() != 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_a3 = e.rd; m_wd = e.data;
            starve = 0;
        end else begin
            m_we = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
            if (acc && wb_if.ld_rd != 5'd0) begin
                byp = 1'b1;
                m_we = 1'b1; m_a3 = wb_if.ld_rd; m_wd = wb_if.ld_data;
            end
`endif
        end
        if (acc && wb_if.ld_rd != 5'd0 && !byp) mq.push_back('{rd: wb_if.ld_rd, data: wb_if.ld_data});
        m_stall = (starve == STARVE_LIMIT);

        @(posedge clk);
        #1;
    endtask

    // Mid-cycle asynchronous reset; the write port and FIFO must clear without waiting for a clock.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_WE3", {31'd0, wb_if.WE3}, 32'd0);
        chk("rst_A3", {27'd0, wb_if.A3}, 32'd0);
        chk("rst_WD3", wb_if.WD3, 32'd0);
        chk("rst_stall", {31'd0, wb_if.stall}, 32'd0);
        chk("rst_ld_count", 32'(wb_if.ld_count), 32'd0);
        chk("rst_ld_ready", {31'd0, wb_if.ld_ready}, 32'd0);
        mq.delete();
        starve = 0; m_we = 1'b0; m_a3 = 5'd0; m_wd = 32'd0; m_stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rel_ld_ready", {31'd0, wb_if.ld_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic av;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset values.
        #12;
        chk("init_WE3", {31'd0, wb_if.WE3}, 32'd0);
        chk("init_A3", {27'd0, wb_if.A3}, 32'd0);
        chk("init_WD3", wb_if.WD3, 32'd0);
        chk("init_stall", {31'd0, wb_if.stall}, 32'd0);
        chk("init_ld_count", 32'(wb_if.ld_count), 32'd0);
        chk("init_ld_ready", {31'd0, wb_if.ld_ready}, 32'd0);
        #10 rst = 1'b1;
        #1;
        chk("init_rel_ready", {31'd0, wb_if.ld_ready}, 32'd1);
        @(posedge clk);
        #1;

        // ALU path, and an ALU write to x0.
        drive(1, 9, 32'h20, 0, 0, 0, 0, 0); step();
        chk("alu_WE3", {31'd0, wb_if.WE3}, 32'd1);
        chk("alu_A3", {27'd0, wb_if.A3}, 32'd9);
        chk("alu_WD3", wb_if.WD3, 32'h20);
        drive(1, 0, 32'h55, 0, 0, 0, 0, 0); step();
        chk("alu_x0_WE3", {31'd0, wb_if.WE3}, 32'd0);

        // Load path with an idle ALU, then a load to x0.
        drive(0, 0, 0, 1, 6, 32'h40, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef WB_LOAD_BYPASS_EN
        chk("ld_byp_WE3", {31'd0, wb_if.WE3}, 32'd1);
        chk("ld_byp_A3", {27'd0, wb_if.A3}, 32'd6);
        chk("ld_byp_WD3", wb_if.WD3, 32'h40);
        step();
`else
        chk("ld_n1_WE3", {31'd0, wb_if.WE3}, 32'd0);
        step();
        chk("ld_n2_WE3", {31'd0, wb_if.WE3}, 32'd1);
        chk("ld_n2_A3", {27'd0, wb_if.A3}, 32'd6);
        chk("ld_n2_WD3", wb_if.WD3, 32'h40);
`endif
        drive(0, 0, 0, 1, 0, 32'h77, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("ld_x0_count", 32'(wb_if.ld_count), 32'd0);
        chk("ld_x0_WE3", {31'd0, wb_if.WE3}, 32'd0);

        // Fill the FIFO under a busy ALU, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 32'(i), 1, 5'(10 + i), 32'(32'h100 + i), 0, 0); step();
        end
        chk("full_count", 32'(wb_if.ld_count), 32'd4);
        chk("full_ready", {31'd0, wb_if.ld_ready}, 32'd0);
        drive(1, 3, 32'h9, 1, 14, 32'h104, 0, 0); step();
        chk("full_hold_count", 32'(wb_if.ld_count), 32'd4);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_A3", {27'd0, wb_if.A3}, 32'(10 + i));
            chk("drain_WD3", wb_if.WD3, 32'(32'h100 + i));
        end

        // Starvation: one load queued behind three blocked cycles.
        drive(1, 4, 32'h1, 1, 5, 32'h55, 0, 0); step();
        drive(1, 4, 32'h2, 0, 0, 0, 0, 0); step(); step();
        chk("starve_pre", {31'd0, wb_if.stall}, 32'd0);
        step();
        chk("starve_on", {31'd0, wb_if.stall}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("starve_pop_A3", {27'd0, wb_if.A3}, 32'd5);
        chk("starve_off", {31'd0, wb_if.stall}, 32'd0);

        // Hazard query on a queued load.
        drive(1, 4, 32'h3, 1, 7, 32'h70, 0, 0); step();
        drive(1, 4, 32'h4, 0, 0, 0, 7, 0);
        #1;
        chk("haz1_on", {31'd0, wb_if.haz1}, 32'd1);
        chk("haz2_x0", {31'd0, wb_if.haz2}, 32'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 7, 0); step();
        chk("haz1_off", {31'd0, wb_if.haz1}, 32'd0);

        // Reset with three entries queued, then no stale writes.
        for (int i = 0; i < 3; i++) begin
            drive(1, 2, 32'(i), 1, 5'(20 + i), 32'(i), 0, 0); step();
        end
        chk("pre_rst_count", 32'(wb_if.ld_count), 32'd3);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_WE3", {31'd0, wb_if.WE3}, 32'd0);
        end

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            av = !m_stall && ($urandom_range(0, 99) < 55);
            drive(av, 5'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (c % 1000 == 999) do_reset();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
